seg_serial_rx: RTL

- Receive end of the 4-wire serial display link (SEGCLK, SEGCLR, SEGDT, SEGEN) that the score path drives with 64-bit seven-segment frames.
- Oversamples the link in the system clock and rebuilds each 64-bit frame.
- Presents the frame in parallel with a valid/error strobe.
- Used as an on-chip loopback monitor for the score display and as a board-side display-register model in simulation.

---
 rtl/seg_serial_rx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seg_serial_rx.sv
// seg_serial_rx: receive end of the 4-wire serial seven-segment display link.
// Oversamples SEGCLK/SEGCLR/SEGDT/SEGEN in clk, rebuilds each frame MSB-first
// and presents it in parallel with a one-cycle valid or error strobe.
module seg_serial_rx #(
    parameter int unsigned FRAME_BITS  = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          SEGCLK,
    input  logic                          SEGCLR,
    input  logic                          SEGDT,
    input  logic                          SEGEN,
    output logic [FRAME_BITS-1:0]         frame,
    output logic                          frame_valid,
    output logic                          frame_err,
    output logic [$clog2(FRAME_BITS):0]   bit_cnt,
    output logic                          busy
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FULL,
        ST_OVER
    } state_t;

    // Receive state is carried entirely by the bit count.
    function automatic state_t decode(input logic [CNT_W-1:0] cnt);
        if (cnt == '0)            return ST_IDLE;
        else if (cnt == CNT_FULL) return ST_FULL;
        else if (cnt == CNT_OVER) return ST_OVER;
        else                      return ST_SHIFT;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic [SYNC_STAGES-1:0] dt_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic                   clk_prev;
    logic                   en_prev;
    logic [FRAME_BITS-1:0]  shreg;

    logic                   clk_s;
    logic                   clr_s;
    logic                   dt_s;
    logic                   en_s;
    logic                   clk_rise;
    logic                   en_rise;
    state_t                 state;

    logic [FRAME_BITS-1:0]  shreg_n;
    logic [FRAME_BITS-1:0]  frame_n;
    logic [CNT_W-1:0]       cnt_n;
    logic                   valid_n;
    logic                   err_n;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign clr_s    = clr_sync[SYNC_STAGES-1];
    assign dt_s     = dt_sync[SYNC_STAGES-1];
    assign en_s     = en_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev;
    assign en_rise  = en_s & ~en_prev;
    assign state    = decode(bit_cnt);

    // Synchronizer chains and edge-history flops for the link pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= '0;
            clr_sync <= '0;
            dt_sync  <= '0;
            en_sync  <= '0;
            clk_prev <= 1'b0;
            en_prev  <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], SEGCLK};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], SEGCLR};
            dt_sync  <= {dt_sync[SYNC_STAGES-2:0], SEGDT};
            en_sync  <= {en_sync[SYNC_STAGES-2:0], SEGEN};
            clk_prev <= clk_s;
            en_prev  <= en_s;
        end
    end

    // Next-state: clear beats latch beats shift; latch is judged on the post-shift count.
    always_comb begin
        shreg_n = shreg;
        frame_n = frame;
        cnt_n   = bit_cnt;
        valid_n = 1'b0;
        err_n   = 1'b0;
        if (!clr_s) begin
            cnt_n   = '0;
            shreg_n = '0;
        end else begin
            if (clk_rise) begin
                shreg_n = {shreg[FRAME_BITS-2:0], dt_s};
                if (state != ST_OVER) begin
                    cnt_n = bit_cnt + CNT_W'(1);
                end
            end
            if (en_rise) begin
                if (decode(cnt_n) == ST_FULL) begin
                    frame_n = shreg_n;
                    valid_n = 1'b1;
                end else begin
                    err_n = 1'b1;
                end
                cnt_n = '0;
            end
        end
    end

    // Receive state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg       <= '0;
            frame       <= '0;
            bit_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            shreg       <= shreg_n;
            frame       <= frame_n;
            bit_cnt     <= cnt_n;
            frame_valid <= valid_n;
            frame_err   <= err_n;
            busy        <= (cnt_n != '0);
        end
    end

endmodule
